// File: rtl/adc_cap_pkg.sv
// adc_cap_pkg: shared definitions for the ADC capture framer.
// Holds the FSM state encoding and the tagged FIFO entry layout used by
// adc_cap_framer and adc_cap_fifo.
package adc_cap_pkg;

  // Raw state codes, kept as plain constants for tools and scripts that
  // decode the state register directly.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_ABORT   = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;

  // Capture FSM states, built on the raw codes above.
  typedef enum logic [2:0] {
    CAP_IDLE    = ST_IDLE,
    CAP_ARMED   = ST_ARMED,
    CAP_CAPTURE = ST_CAPTURE,
    CAP_ABORT   = ST_ABORT,
    CAP_DRAIN   = ST_DRAIN
  } cap_state_e;

  // Default ADC beat width. The FIFO entry is one tag bit above the data.
  localparam int CAP_DATA_W = 128;

  // FIFO entry: end-of-packet tag in the MSB, beat data below it.
  typedef struct packed {
    logic                  last;
    logic [CAP_DATA_W-1:0] data;
  } cap_tag_t;

endpackage

// File: rtl/adc_cap_fifo.sv
// adc_cap_fifo: synchronous first-word-fall-through FIFO.
// The head entry is always visible on rd_data while the FIFO is non-empty.
// A write while full succeeds when a read happens in the same cycle.
module adc_cap_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/adc_cap_framer.sv
// adc_cap_framer: gates the free-running ADC stream into one packet of
// cap_size beats per software start, buffers it against downstream
// back-pressure and always closes the packet with tlast.
// Optional feature macro: ADC_CAP_TRIG_EN compiles in the level trigger
// and the ARMED state; without it trig_mode/trig_level are ignored.
module adc_cap_framer
  import adc_cap_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                rf_clk,
  input  logic                rf_rst,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  input  logic                cap_start,
  input  logic [31:0]         cap_size,
  input  logic                trig_mode,
  input  logic [SAMPLE_W-1:0] trig_level,
  output logic                cap_done,
  output logic                cap_overflow,
  output logic [31:0]         beats_captured
);

  localparam int NS = DATA_W / SAMPLE_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  cap_state_e        state;
  logic [31:0]       size_q;
  logic [DATA_W:0]   wr_entry;
  logic [DATA_W:0]   rd_entry;
  logic              fifo_wr;
  logic              fifo_rd;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              start_ok;
  logic              beat_last;
  logic              wr_room;
  logic              cap_beat;
  logic              overflow_hit;
  logic              trig_hit;

  // The ADC cannot be stalled, so the input is always ready.
  assign s_axis_tready = 1'b1;

  assign start_ok  = cap_start && (cap_size != 32'd0);
  assign beat_last = (beats_captured == size_q - 32'd1);
  assign fifo_rd   = m_axis_tvalid && m_axis_tready;
  assign wr_room   = !fifo_full || fifo_rd;
  assign wr_entry  = {beat_last, s_axis_tdata};

`ifdef ADC_CAP_TRIG_EN
  // Trigger fires when any signed sample in the beat reaches the threshold.
  always_comb begin
    trig_hit = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if ($signed(s_axis_tdata[i*SAMPLE_W +: SAMPLE_W]) >= $signed(trig_level))
        trig_hit = 1'b1;
    end
  end
`else
  logic unused_trig;
  assign trig_hit    = 1'b0;
  assign unused_trig = ^{trig_mode, trig_level};
`endif

  // Decide whether the current input beat belongs to the packet, and
  // whether it fits into the FIFO or overflows it.
  always_comb begin
    cap_beat = 1'b0;
    case (state)
      CAP_CAPTURE: cap_beat = s_axis_tvalid;
      CAP_ARMED:   cap_beat = s_axis_tvalid && trig_hit;
      default:     cap_beat = 1'b0;
    endcase
    fifo_wr      = cap_beat && wr_room;
    overflow_hit = cap_beat && !wr_room;
  end

  adc_cap_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (rf_clk),
    .rst     (rf_rst),
    .wr_en   (fifo_wr),
    .wr_data (wr_entry),
    .rd_en   (fifo_rd),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Output side: data is masked to zero while empty so the idle bus is clean.
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : rd_entry[DATA_W-1:0];

  // tlast follows the stored tag, except after an overflow where the last
  // remaining entry is forced to close the packet.
  always_comb begin
    m_axis_tlast = 1'b0;
    if (!fifo_empty) begin
      if (state == CAP_ABORT) m_axis_tlast = (fifo_count == CW'(1));
      else                    m_axis_tlast = rd_entry[DATA_W];
    end
  end

  // Capture sequencing: start, optional arm, capture, then drain or abort.
  always_ff @(posedge rf_clk) begin
    if (rf_rst) begin
      state          <= CAP_IDLE;
      size_q         <= 32'd0;
      cap_done       <= 1'b0;
      cap_overflow   <= 1'b0;
      beats_captured <= 32'd0;
    end else begin
      case (state)
        CAP_IDLE: begin
          if (start_ok) begin
            size_q         <= cap_size;
            cap_done       <= 1'b0;
            cap_overflow   <= 1'b0;
            beats_captured <= 32'd0;
`ifdef ADC_CAP_TRIG_EN
            state <= trig_mode ? CAP_ARMED : CAP_CAPTURE;
`else
            state <= CAP_CAPTURE;
`endif
          end
        end
        CAP_ARMED, CAP_CAPTURE: begin
          if (fifo_wr) begin
            beats_captured <= beats_captured + 32'd1;
            state          <= beat_last ? CAP_DRAIN : CAP_CAPTURE;
          end else if (overflow_hit) begin
            cap_overflow <= 1'b1;
            if (fifo_empty) begin
              state    <= CAP_IDLE;
              cap_done <= 1'b1;
            end else begin
              state <= CAP_ABORT;
            end
          end
        end
        CAP_ABORT: begin
          if (fifo_rd && fifo_count == CW'(1)) begin
            state    <= CAP_IDLE;
            cap_done <= 1'b1;
          end
        end
        CAP_DRAIN: begin
          if (fifo_rd && rd_entry[DATA_W]) begin
            state    <= CAP_IDLE;
            cap_done <= 1'b1;
          end
        end
        default: state <= CAP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_cap_framer.sv
// tb_adc_cap_framer: randomized bench for adc_cap_framer with a queue-based
// reference model and per-cycle output comparison.
module tb_adc_cap_framer;

  localparam int DATA_W     = 128;
  localparam int SAMPLE_W   = 16;
  localparam int FIFO_DEPTH = 64;
  localparam int NS         = DATA_W / SAMPLE_W;
`ifdef ADC_CAP_TRIG_EN
  localparam bit TRIG_EN = 1'b1;
`else
  localparam bit TRIG_EN = 1'b0;
`endif

  logic                rf_clk;
  logic                rf_rst;
  logic [DATA_W-1:0]   s_axis_tdata;
  logic                s_axis_tvalid;
  logic                s_axis_tready;
  logic [DATA_W-1:0]   m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic                m_axis_tlast;
  logic                cap_start;
  logic [31:0]         cap_size;
  logic                trig_mode;
  logic [SAMPLE_W-1:0] trig_level;
  logic                cap_done;
  logic                cap_overflow;
  logic [31:0]         beats_captured;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  adc_cap_framer #(
    .DATA_W     (DATA_W),
    .SAMPLE_W   (SAMPLE_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .rf_clk         (rf_clk),
    .rf_rst         (rf_rst),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .cap_start      (cap_start),
    .cap_size       (cap_size),
    .trig_mode      (trig_mode),
    .trig_level     (trig_level),
    .cap_done       (cap_done),
    .cap_overflow   (cap_overflow),
    .beats_captured (beats_captured)
  );

  initial rf_clk = 1'b0;
  always #5 rf_clk = ~rf_clk;

  typedef struct {
    bit          last;
    logic [127:0] data;
  } beat_t;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_CAP   = 2;
  localparam int M_ABORT = 3;
  localparam int M_DRAIN = 4;

  beat_t       mq[$];
  int          m_phase = M_IDLE;
  bit          m_done  = 1'b0;
  bit          m_ovf   = 1'b0;
  logic [31:0] m_cnt   = 32'd0;
  logic [31:0] m_size  = 32'd0;

  function automatic bit anyGe(input logic [127:0] d, input logic [15:0] lvl);
    for (int i = 0; i < NS; i++)
      if ($signed(d[i*SAMPLE_W +: SAMPLE_W]) >= $signed(lvl)) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge rf_clk) begin
    int occ;
    bit front_last;
    bit hs;
    bit room;
    bit take;
    if (rf_rst) begin
      mq.delete();
      m_phase = M_IDLE;
      m_done  = 1'b0;
      m_ovf   = 1'b0;
      m_cnt   = 32'd0;
      m_size  = 32'd0;
    end else begin
      occ        = mq.size();
      front_last = (occ > 0) ? mq[0].last : 1'b0;
      hs         = (occ > 0) && m_axis_tready;
      room       = (occ < FIFO_DEPTH) || hs;
      take       = 1'b0;
      if (m_phase == M_CAP)   take = s_axis_tvalid;
      if (m_phase == M_ARMED) take = s_axis_tvalid && anyGe(s_axis_tdata, trig_level);
      if (hs) void'(mq.pop_front());
      case (m_phase)
        M_IDLE: if (cap_start && cap_size != 32'd0) begin
          m_size  = cap_size;
          m_done  = 1'b0;
          m_ovf   = 1'b0;
          m_cnt   = 32'd0;
          m_phase = (TRIG_EN && trig_mode) ? M_ARMED : M_CAP;
        end
        M_ARMED, M_CAP: if (take) begin
          if (room) begin
            mq.push_back('{last: (m_cnt + 32'd1 == m_size), data: s_axis_tdata});
            m_cnt   = m_cnt + 32'd1;
            m_phase = (m_cnt == m_size) ? M_DRAIN : M_CAP;
          end else begin
            m_ovf   = 1'b1;
            m_phase = M_ABORT;
          end
        end
        M_ABORT: if (hs && occ == 1) begin
          m_phase = M_IDLE;
          m_done  = 1'b1;
        end
        M_DRAIN: if (hs && front_last) begin
          m_phase = M_IDLE;
          m_done  = 1'b1;
        end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge rf_clk) begin
    int occ;
    bit exp_last;
    logic [127:0] exp_data;
    if (chk_en) begin
      occ      = mq.size();
      exp_data = (occ > 0) ? mq[0].data : 128'd0;
      exp_last = (occ > 0) && ((m_phase == M_ABORT) ? (occ == 1) : mq[0].last);
      checkOutput("s_axis_tready", s_axis_tready, 1'b1);
      checkOutput("m_axis_tvalid", m_axis_tvalid, occ > 0);
      checkOutput("m_axis_tdata", m_axis_tdata, exp_data);
      checkOutput("m_axis_tlast", m_axis_tlast, exp_last);
      checkOutput("cap_done", cap_done, m_done);
      checkOutput("cap_overflow", cap_overflow, m_ovf);
      checkOutput("beats_captured", beats_captured, m_cnt);
    end
  end

  // Record every accepted output beat for packet-level checks.
  beat_t rx_q[$];
  always @(negedge rf_clk) begin
    if (chk_en && !rf_rst && m_axis_tvalid && m_axis_tready)
      rx_q.push_back('{last: m_axis_tlast, data: m_axis_tdata});
  end

  // ---------------- stimulus ----------------
  bit use_ramp = 1'b0;
  int ramp_k   = 0;

  function automatic logic [127:0] makeBeat(input logic [15:0] v);
    logic [127:0] b;
    for (int i = 0; i < NS; i++) b[i*SAMPLE_W +: SAMPLE_W] = v;
    return b;
  endfunction

  function automatic logic [127:0] nextData();
    if (use_ramp) begin
      ramp_k++;
      return makeBeat(16'(ramp_k * 25));
    end
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic applyStimulus(input bit start, input logic [31:0] size, input bit valid,
                               input logic [127:0] data, input bit ready);
    cap_start     = start;
    cap_size      = size;
    s_axis_tvalid = valid;
    s_axis_tdata  = data;
    m_axis_tready = ready;
    @(posedge rf_clk);
    #2;
  endtask

  task automatic startCapture(input logic [31:0] size, input bit mode);
    trig_mode = mode;
    applyStimulus(1'b1, size, 1'b1, use_ramp ? makeBeat(16'd0) : nextData(), 1'b1);
  endtask

  task automatic runCycles(input int n, input int ready_pct, input int valid_pct);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, $urandom, ($urandom_range(0, 99) < valid_pct), nextData(),
                    ($urandom_range(0, 99) < ready_pct));
  endtask

  task automatic waitDone(input int budget, input int ready_pct, input int valid_pct);
    for (int i = 0; i < budget; i++) begin
      if (cap_done) break;
      applyStimulus(1'b0, $urandom, ($urandom_range(0, 99) < valid_pct), nextData(),
                    ($urandom_range(0, 99) < ready_pct));
    end
    checkOutput("done_within_budget", cap_done, 1'b1);
    cap_start     = 1'b0;
    m_axis_tready = 1'b0;
  endtask

  function automatic int countLasts();
    int n = 0;
    foreach (rx_q[i]) if (rx_q[i].last) n++;
    return n;
  endfunction

  initial begin
    rf_rst        = 1'b1;
    cap_start     = 1'b0;
    cap_size      = 32'd0;
    trig_mode     = 1'b0;
    trig_level    = 16'd0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    @(posedge rf_clk);
    #2;
    chk_en = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b1, nextData(), 1'b1);
    rf_rst = 1'b0;

    // Reset state
    checkOutput("rst_tvalid", m_axis_tvalid, 1'b0);
    checkOutput("rst_tlast", m_axis_tlast, 1'b0);
    checkOutput("rst_tdata", m_axis_tdata, 128'd0);
    checkOutput("rst_done", cap_done, 1'b0);
    checkOutput("rst_beats", beats_captured, 32'd0);

    // Immediate capture of 16 beats
    $display("[TB] immediate capture, 16 beats");
    rx_q.delete();
    startCapture(32'd16, 1'b0);
    waitDone(200, 100, 100);
    checkOutput("imm_rx_count", rx_q.size(), 16);
    checkOutput("imm_last_pos", rx_q[15].last, 1'b1);
    checkOutput("imm_last_count", countLasts(), 1);
    checkOutput("imm_beats", beats_captured, 32'd16);

    // Ramp capture: trigger at beat 40 (value 1000) or immediate when compiled out
    $display("[TB] ramp capture, trig_mode=1, level 1000");
    rx_q.delete();
    trig_level = 16'd1000;
    use_ramp   = 1'b1;
    ramp_k     = 0;
    startCapture(32'd8, 1'b1);
    waitDone(200, 100, 100);
    use_ramp = 1'b0;
    checkOutput("ramp_rx_count", rx_q.size(), 8);
    checkOutput("ramp_first", rx_q[0].data[15:0], TRIG_EN ? 16'd1000 : 16'd25);
    checkOutput("ramp_last_pos", rx_q[7].last, 1'b1);

    // Overflow under full back-pressure
    $display("[TB] overflow, cap_size 200 with tready low");
    rx_q.delete();
    startCapture(32'd200, 1'b0);
    runCycles(80, 0, 100);
    checkOutput("ovf_flag", cap_overflow, 1'b1);
    checkOutput("ovf_beats", beats_captured, 32'd64);
    checkOutput("ovf_not_done", cap_done, 1'b0);
    waitDone(200, 100, 100);
    checkOutput("ovf_rx_count", rx_q.size(), 64);
    checkOutput("ovf_last_pos", rx_q[63].last, 1'b1);
    checkOutput("ovf_last_count", countLasts(), 1);

    // Single-beat capture
    $display("[TB] cap_size 1");
    rx_q.delete();
    startCapture(32'd1, 1'b0);
    waitDone(50, 100, 100);
    checkOutput("one_rx_count", rx_q.size(), 1);
    checkOutput("one_last", rx_q[0].last, 1'b1);

    // Zero-size start is ignored
    $display("[TB] cap_size 0");
    rx_q.delete();
    startCapture(32'd0, 1'b0);
    runCycles(10, 100, 100);
    checkOutput("zero_rx_count", rx_q.size(), 0);
    checkOutput("zero_beats", beats_captured, 32'd1);
    checkOutput("zero_done_kept", cap_done, 1'b1);

    // Start during capture is ignored
    $display("[TB] start during capture");
    rx_q.delete();
    startCapture(32'd32, 1'b0);
    runCycles(5, 50, 100);
    applyStimulus(1'b1, 32'd5, 1'b1, nextData(), 1'b1);
    waitDone(300, 60, 100);
    checkOutput("restart_rx_count", rx_q.size(), 32);
    checkOutput("restart_beats", beats_captured, 32'd32);

    // Reset in the middle of a capture
    $display("[TB] reset at beat 5 of 32");
    startCapture(32'd32, 1'b0);
    runCycles(5, 0, 100);
    rf_rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b1, nextData(), 1'b0);
    rf_rst = 1'b0;
    checkOutput("mid_rst_tvalid", m_axis_tvalid, 1'b0);
    checkOutput("mid_rst_tlast", m_axis_tlast, 1'b0);
    checkOutput("mid_rst_beats", beats_captured, 32'd0);
    rx_q.delete();
    startCapture(32'd32, 1'b0);
    waitDone(400, 60, 70);
    checkOutput("post_rst_rx_count", rx_q.size(), 32);
    checkOutput("post_rst_last", rx_q[31].last, 1'b1);

    // Randomized captures
    for (int n = 0; n < 6; n++) begin
      int sz;
      int rp;
      int vp;
      sz = $urandom_range(1, 100);
      rp = $urandom_range(20, 100);
      vp = $urandom_range(50, 100);
      trig_level = 16'($urandom_range(0, 40000) - 20000);
      $display("[TB] random capture %0d: size %0d ready %0d%% valid %0d%%", n, sz, rp, vp);
      rx_q.delete();
      startCapture(sz, 1'($urandom_range(0, 1)));
      waitDone(3000, rp, vp);
      checkOutput("rand_terminated", (rx_q.size() > 0) ? rx_q[rx_q.size()-1].last : 1'b0, 1'b1);
      checkOutput("rand_last_count", countLasts(), 1);
    end

    runCycles(4, 100, 100);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_cap_framer.md
# adc_cap_framer

Capture framer between the RF data converter's ADC AXIS output and `adc_data_path`, one instance per ADC channel. Gates the free-running, non-stallable ADC sample stream into one packet of `cap_size` beats per software start, optionally on a sample-level trigger. Absorbs downstream back-pressure in a local FIFO and always terminates the packet with `tlast`, so the datamover downstream never hangs.

## Interface
Parameters:
- `DATA_W`, 128, ADC AXIS beat width.
- `SAMPLE_W`, 16, signed sample width; `DATA_W/SAMPLE_W` samples per beat, sample 0 in LSBs.
- `FIFO_DEPTH`, 64, elasticity FIFO entries; power of two, ≥4.

Ports:
- `rf_clk`  in  1  ADC stream clock; the only clock.
- `rf_rst`  in  1  synchronous, active-high reset.
- `s_axis_tdata`  in  DATA_W  ADC samples.
- `s_axis_tvalid`  in  1  sample beat valid.
- `s_axis_tready`  out  1  tied 1; the ADC cannot stall.
- `m_axis_tdata`  out  DATA_W  captured beat to `adc_data_path`.
- `m_axis_tvalid`  out  1  captured beat valid.
- `m_axis_tready`  in  1  downstream accept.
- `m_axis_tlast`  out  1  final beat of capture packet.
- `cap_start`  in  1  single-cycle start pulse.
- `cap_size`  in  32  beats per capture; sampled on accepted start.
- `trig_mode`  in  1  0 = immediate, 1 = level trigger.
- `trig_level`  in  SAMPLE_W  signed trigger threshold.
- `cap_done`  out  1  sticky; capture finished, cleared by next accepted start.
- `cap_overflow`  out  1  sticky; FIFO overflowed during capture, cleared by next accepted start.
- `beats_captured`  out  32  beats written into the FIFO this capture.

## Operation
- States: IDLE, ARMED, CAPTURE, ABORT, DRAIN.
- IDLE: `cap_start` with `cap_size != 0` latches `cap_size`, clears `cap_done`, `cap_overflow`, `beats_captured` → ARMED if `trig_mode=1`, else CAPTURE. `cap_size == 0` start is ignored. Start is ignored in every other state.
- ARMED: each valid beat is compared per sample: trigger if any signed sample ≥ `trig_level`. The triggering beat is the first captured beat. Same cycle → CAPTURE.
- CAPTURE: each valid beat is written to the FIFO with tag `last = (count == cap_size-1)`, and `beats_captured` increments. Writing the last-tagged beat → DRAIN.
- Overflow: a valid beat arriving with the FIFO full is dropped and sets `cap_overflow` → ABORT. No further writes occur.
- ABORT: the output forces `m_axis_tlast=1` on the beat presented while FIFO occupancy is 1. That handshake → IDLE with `cap_done=1`. If the FIFO is already empty at overflow (not possible when `FIFO_DEPTH ≥ 1`), go straight to IDLE.
- DRAIN: handshake of the last-tagged beat → IDLE, `cap_done=1`.
- Output is first-word-fall-through: `m_axis_tvalid` = FIFO non-empty; `tlast` = stored tag, or the ABORT rule above.
- Reset mid-operation flushes the FIFO and returns to IDLE. No partial `tlast` is emitted.
- Reset values: `m_axis_tvalid=0`, `m_axis_tlast=0`, `m_axis_tdata=0`, `cap_done=0`, `cap_overflow=0`, `beats_captured=0`, state IDLE.

## Timing
- Start accepted in cycle N. First beat can be written in N+1.
- An input beat written in cycle N is visible on `m_axis` in N+1 when the FIFO was empty.
- Simultaneous FIFO write and read when full: the read frees the slot, so the write succeeds (no overflow).
- `cap_done` rises the cycle after the final handshake.
- Count compare is 32-bit unsigned. `cap_size = 1` yields a single beat with `tlast=1`.

## Configuration
- `ADC_CAP_TRIG_EN` defined: level trigger and ARMED state compiled in.
- Not defined: `trig_mode` and `trig_level` are ignored, and start always goes directly to CAPTURE.

## Structure
- Package `adc_cap_pkg`: state enum `cap_state_e` and the FIFO tag struct `{last, data}`.
- Sub-module `adc_cap_fifo`: synchronous FWFT FIFO with `full`, `empty`, and `count`. The FIFO entry is `DATA_W+1` bits wide.

## Test plan
- Immediate capture: `cap_size=16`, `m_axis_tready=1` → 16 beats out, `tlast` on beat 16, `cap_done=1`, `beats_captured=16`.
- Level trigger: `trig_level=1000`, ramp input crossing 1000 at beat 40 → first output beat is beat 40, with 8 beats for `cap_size=8`.
- Back-pressure overflow: `FIFO_DEPTH=64`, `cap_size=200`, `tready=0` → `cap_overflow=1`; on release, exactly 64 beats drain with `tlast` on beat 64, then `cap_done=1`.
- Boundaries: `cap_size=1` → one beat with `tlast`; `cap_size=0` start → stays IDLE; start during CAPTURE → ignored, count unchanged.
- Reset at beat 5 of 32 → outputs at reset values, FIFO empty; a new start captures a full 32 beats.
- Macro off: `trig_mode=1` with start → capture begins on the next valid beat.
